// File: rtl/convpress_edram_packer.sv
// Output packer for the convpress N3 compressor: packs compacted (value, index)
// groups into dense Tn-entry eDRAM lines written at auto-incrementing addresses.
module convpress_edram_packer #(
    parameter int N         = 16,
    parameter int Tn        = 16,
    parameter int OFFSET_SZ = 4,
    parameter int EADDR_SZ  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [EADDR_SZ-1:0]     i_base_addr,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [Tn*N-1:0]         i_data,
    input  logic [Tn*OFFSET_SZ-1:0] i_idx,
    input  logic [OFFSET_SZ:0]      i_count,
    input  logic                    i_flush,
    output logic                    o_wr_en,
    input  logic                    i_wr_ready,
    output logic [EADDR_SZ-1:0]     o_wr_addr,
    output logic [Tn*N-1:0]         o_wr_data,
    output logic [Tn*OFFSET_SZ-1:0] o_wr_idx,
    output logic [OFFSET_SZ:0]      o_wr_count,
    output logic [EADDR_SZ-1:0]     o_lines,
    output logic                    o_done
);

    localparam int DEPTH = 2 * Tn;
    localparam int F_W   = $clog2(DEPTH);
    localparam int CNT_W = OFFSET_SZ + 1;

    localparam logic [F_W-1:0]   TN_F = F_W'(Tn);
    localparam logic [CNT_W-1:0] TN_C = CNT_W'(Tn);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t state_q, state_n;

    logic [F_W-1:0]      f_q, f_n;
    logic [EADDR_SZ-1:0] addr_q, addr_n;
    logic [EADDR_SZ-1:0] lines_q, lines_n;

    logic [DEPTH-1:0][N-1:0]         buf_data_q, buf_data_n;
    logic [DEPTH-1:0][OFFSET_SZ-1:0] buf_idx_q, buf_idx_n;

    logic                        wr_en_q, wr_en_n;
    logic [EADDR_SZ-1:0]         wr_addr_q;
    logic [Tn-1:0][N-1:0]        wr_data_q, wr_data_n;
    logic [Tn-1:0][OFFSET_SZ-1:0] wr_idx_q, wr_idx_n;
    logic [CNT_W-1:0]            wr_count_q, wr_count_n;

    logic [CNT_W-1:0] take;
    logic             accept;
    logic             wr_fire;

    assign o_ready = (state_q == RUN) && (f_q < TN_F);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n    = state_q;
        f_n        = f_q;
        addr_n     = addr_q;
        lines_n    = lines_q;
        buf_data_n = buf_data_q;
        buf_idx_n  = buf_idx_q;

        take    = (i_count > TN_C) ? TN_C : i_count;
        accept  = i_valid && o_ready;
        wr_fire = wr_en_q && i_wr_ready;

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_n    = RUN;
                    addr_n     = i_base_addr;
                    f_n        = '0;
                    lines_n    = '0;
                    buf_data_n = '0;
                    buf_idx_n  = '0;
                end
            end
            RUN:     if (i_flush) state_n = FLUSH;
            FLUSH:   if (f_q == '0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Accept only happens with F < Tn, so F+k never leaves the buffer.
        if (accept) begin
            for (int k = 0; k < Tn; k++) begin
                if (k < int'(take)) begin
                    buf_data_n[int'(f_q) + k] = i_data[k*N +: N];
                    buf_idx_n[int'(f_q) + k]  = i_idx[k*OFFSET_SZ +: OFFSET_SZ];
                end
            end
            f_n = f_q + F_W'(take);
        end

        if (wr_fire) begin
            buf_data_n = {{(Tn*N){1'b0}}, buf_data_q[DEPTH-1:Tn]};
            buf_idx_n  = {{(Tn*OFFSET_SZ){1'b0}}, buf_idx_q[DEPTH-1:Tn]};
            f_n        = (f_q >= TN_F) ? (f_q - TN_F) : '0;
            addr_n     = addr_q + EADDR_SZ'(1);
            lines_n    = lines_q + EADDR_SZ'(1);
        end
    end

    // The write port is registered from next state, so o_wr_* hold steady on a stall.
    always_comb begin
        wr_en_n    = ((state_n == RUN) && (f_n >= TN_F)) ||
                     ((state_n == FLUSH) && (f_n != '0));
        wr_count_n = (f_n >= TN_F) ? TN_C : CNT_W'(f_n);
        wr_data_n  = '0;
        wr_idx_n   = '0;
        for (int k = 0; k < Tn; k++) begin
            if (k < int'(wr_count_n)) begin
                wr_data_n[k] = buf_data_n[k];
                wr_idx_n[k]  = buf_idx_n[k];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            f_q        <= '0;
            addr_q     <= '0;
            lines_q    <= '0;
            // NOTE: the staging buffer is reset as well, since reset must leave
            // no stale entries behind; it is small enough to live in flops.
            buf_data_q <= '0;
            buf_idx_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_idx_q   <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_n;
            f_q        <= f_n;
            addr_q     <= addr_n;
            lines_q    <= lines_n;
            buf_data_q <= buf_data_n;
            buf_idx_q  <= buf_idx_n;
            wr_en_q    <= wr_en_n;
            wr_addr_q  <= addr_n;
            wr_data_q  <= wr_data_n;
            wr_idx_q   <= wr_idx_n;
            wr_count_q <= wr_count_n;
        end
    end

    assign o_wr_en    = wr_en_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_wr_idx   = wr_idx_q;
    assign o_wr_count = wr_count_q;
    assign o_lines    = lines_q;
    assign o_done     = (state_q == DONE);

endmodule

// File: tb/tb_convpress_edram_packer.sv
// Directed bench for convpress_edram_packer: a group table plus hand-written
// sequences for address wrap, write stall, flush and mid-stream reset.
module tb_convpress_edram_packer;

    localparam int N         = 16;
    localparam int Tn        = 16;
    localparam int OFFSET_SZ = 4;
    localparam int EADDR_SZ  = 10;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    i_start = 1'b0;
    logic [EADDR_SZ-1:0]     i_base_addr = '0;
    logic                    i_valid = 1'b0;
    logic                    o_ready;
    logic [Tn*N-1:0]         i_data = '0;
    logic [Tn*OFFSET_SZ-1:0] i_idx = '0;
    logic [OFFSET_SZ:0]      i_count = '0;
    logic                    i_flush = 1'b0;
    logic                    o_wr_en;
    logic                    i_wr_ready = 1'b1;
    logic [EADDR_SZ-1:0]     o_wr_addr;
    logic [Tn*N-1:0]         o_wr_data;
    logic [Tn*OFFSET_SZ-1:0] o_wr_idx;
    logic [OFFSET_SZ:0]      o_wr_count;
    logic [EADDR_SZ-1:0]     o_lines;
    logic                    o_done;

    convpress_edram_packer #(
        .N(N), .Tn(Tn), .OFFSET_SZ(OFFSET_SZ), .EADDR_SZ(EADDR_SZ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_base_addr(i_base_addr),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_idx      (i_idx),
        .i_count    (i_count),
        .i_flush    (i_flush),
        .o_wr_en    (o_wr_en),
        .i_wr_ready (i_wr_ready),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_wr_idx   (o_wr_idx),
        .o_wr_count (o_wr_count),
        .o_lines    (o_lines),
        .o_done     (o_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard: entries in acceptance order, consumed line by line.
    logic [N-1:0]         exp_val_q[$];
    logic [OFFSET_SZ-1:0] exp_idx_q[$];
    logic [EADDR_SZ-1:0]  exp_addr = '0;
    int                   n_writes = 0;
    int                   n_done   = 0;

    always @(negedge clk) begin
        if (rst && o_done) n_done++;
        if (rst && o_wr_en && i_wr_ready) begin
            int                      cnt;
            logic [Tn*N-1:0]         ed;
            logic [Tn*OFFSET_SZ-1:0] ei;
            cnt = (exp_val_q.size() < Tn) ? exp_val_q.size() : Tn;
            ed  = '0;
            ei  = '0;
            for (int k = 0; k < cnt; k++) begin
                ed[k*N +: N]                 = exp_val_q.pop_front();
                ei[k*OFFSET_SZ +: OFFSET_SZ] = exp_idx_q.pop_front();
            end
            check("wr_addr", 256'(o_wr_addr), 256'(exp_addr));
            check("wr_count", 256'(o_wr_count), 256'(cnt));
            check("wr_data", 256'(o_wr_data), 256'(ed));
            check("wr_idx", 256'(o_wr_idx), 256'(ei));
            exp_addr = exp_addr + 10'd1;
            n_writes++;
        end
    end

    function automatic logic [Tn*N-1:0] line_of(input logic [7:0] tag);
        logic [Tn*N-1:0] d;
        for (int k = 0; k < Tn; k++) d[k*N +: N] = {tag, 8'(k)};
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!o_ready && t < 50) begin
            tick();
            t++;
        end
        if (!o_ready) begin
            n_checks++;
            $display("FAIL ready_timeout: o_ready=%0b after %0d cycles, expected 1", o_ready, t);
        end
    endtask

    task automatic start(input logic [EADDR_SZ-1:0] base, input logic with_flush);
        exp_addr    = base;
        i_base_addr = base;
        i_start     = 1'b1;
        i_flush     = with_flush;
        tick();
        i_start = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic send_group(input logic [OFFSET_SZ:0] count, input logic [7:0] tag);
        int c;
        wait_ready();
        for (int k = 0; k < Tn; k++) begin
            i_data[k*N +: N]                 = {tag, 8'(k)};
            i_idx[k*OFFSET_SZ +: OFFSET_SZ]  = 4'(k + int'(tag));
        end
        i_count = count;
        i_valid = 1'b1;
        c = (int'(count) > Tn) ? Tn : int'(count);
        for (int k = 0; k < c; k++) begin
            exp_val_q.push_back({tag, 8'(k)});
            exp_idx_q.push_back(4'(k + int'(tag)));
        end
        tick();
        i_valid = 1'b0;
    endtask

    task automatic flush_and_wait(input string name);
        int d0;
        int t;
        d0 = n_done;
        t  = 0;
        wait_ready();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        while (n_done == d0 && t < 100) begin
            tick();
            t++;
        end
        repeat (4) tick();
        check({name, "_done_pulses"}, 256'(n_done - d0), 256'(1));
        check({name, "_idle_ready"}, 256'(o_ready), 256'(0));
    endtask

    typedef struct {
        logic [OFFSET_SZ:0]  count;
        logic [7:0]          tag;
        logic [EADDR_SZ-1:0] exp_lines;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int w0;
        int d0;

        vecs[0] = '{5'd8,  8'h11, 10'd0};
        vecs[1] = '{5'd8,  8'h12, 10'd1};
        vecs[2] = '{5'd8,  8'h13, 10'd1};
        vecs[3] = '{5'd8,  8'h14, 10'd2};
        vecs[4] = '{5'd0,  8'h15, 10'd2};
        vecs[5] = '{5'd20, 8'h16, 10'd3};
        vecs[6] = '{5'd12, 8'h17, 10'd3};
        vecs[7] = '{5'd12, 8'h18, 10'd4};

        // Asynchronous reset: outputs clear before any clock edge.
        #3 rst = 1'b0;
        #1;
        check("rst_ready", 256'(o_ready), 256'(0));
        check("rst_wr_en", 256'(o_wr_en), 256'(0));
        check("rst_wr_addr", 256'(o_wr_addr), 256'(0));
        check("rst_wr_data", 256'(o_wr_data), 256'(0));
        check("rst_wr_idx", 256'(o_wr_idx), 256'(0));
        check("rst_wr_count", 256'(o_wr_count), 256'(0));
        check("rst_lines", 256'(o_lines), 256'(0));
        check("rst_done", 256'(o_done), 256'(0));
        tick();
        tick();
        rst = 1'b1;

        // Group table: full lines, zero-count group, clamped group, partial tail.
        start(10'h010, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_group(vecs[i].count, vecs[i].tag);
            repeat (3) tick();
            check($sformatf("lines_v%0d", i), 256'(o_lines), 256'(vecs[i].exp_lines));
            check($sformatf("idle_wr_en_v%0d", i), 256'(o_wr_en), 256'(0));
        end
        flush_and_wait("tbl_flush");
        check("tbl_lines_final", 256'(o_lines), 256'(5));
        check("tbl_writes", 256'(n_writes), 256'(5));

        // Address wrap; i_flush alongside i_start in IDLE must be ignored.
        d0 = n_done;
        start(10'h3FF, 1'b1);
        check("start_flush_ready", 256'(o_ready), 256'(1));
        repeat (4) tick();
        check("start_flush_no_done", 256'(n_done - d0), 256'(0));
        check("start_flush_still_run", 256'(o_ready), 256'(1));
        send_group(5'd16, 8'h21);
        check("min_latency_wr_en", 256'(o_wr_en), 256'(1));
        send_group(5'd16, 8'h22);
        repeat (3) tick();
        check("wrap_lines", 256'(o_lines), 256'(2));
        check("wrap_next_addr", 256'(exp_addr), 256'(10'h001));
        w0 = n_writes;
        flush_and_wait("empty_flush");
        check("empty_flush_no_write", 256'(n_writes - w0), 256'(0));

        // Write stall: line must hold steady and input stays blocked.
        start(10'h100, 1'b0);
        i_wr_ready = 1'b0;
        send_group(5'd16, 8'h31);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_ctl_%0d", i), 256'({o_wr_en, o_ready, o_wr_addr, o_wr_count}),
                  256'({1'b1, 1'b0, 10'h100, 5'd16}));
            check($sformatf("stall_data_%0d", i), 256'(o_wr_data), 256'(line_of(8'h31)));
        end
        @(posedge clk);
        #1;
        w0 = n_writes;
        i_wr_ready = 1'b1;
        tick();
        check("stall_one_write", 256'(n_writes - w0), 256'(1));
        check("stall_wr_en_low", 256'(o_wr_en), 256'(0));
        repeat (3) tick();
        check("stall_still_one", 256'(n_writes - w0), 256'(1));
        check("stall_ready_back", 256'(o_ready), 256'(1));
        flush_and_wait("stall_flush");

        // Mid-stream reset with F=10, then a clean restart.
        start(10'h200, 1'b0);
        send_group(5'd16, 8'h41);
        repeat (3) tick();
        check("pre_rst_lines", 256'(o_lines), 256'(1));
        send_group(5'd10, 8'h42);
        tick();
        #1 rst = 1'b0;
        #1;
        check("mid_rst_lines", 256'(o_lines), 256'(0));
        check("mid_rst_ready", 256'(o_ready), 256'(0));
        check("mid_rst_wr", 256'({o_wr_en, o_wr_addr, o_wr_count, o_done}), 256'(0));
        check("mid_rst_wr_data", 256'(o_wr_data), 256'(0));
        exp_val_q.delete();
        exp_idx_q.delete();
        tick();
        rst = 1'b1;
        tick();
        start(10'h020, 1'b0);
        check("restart_lines", 256'(o_lines), 256'(0));
        send_group(5'd16, 8'h51);
        repeat (3) tick();
        check("restart_lines_after", 256'(o_lines), 256'(1));
        flush_and_wait("restart_flush");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 ns, expected to finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/convpress_edram_packer.md
# convpress_edram_packer

Output packer downstream of the convpress node's N3 compressor. It accepts compacted groups of non-zero values with their indices, and packs them densely into full Tn-entry eDRAM lines. Each line is written at an auto-incrementing eDRAM address under a valid/ready handshake. On flush it drains any remaining partial line, then signals completion.

## Interface
- N, 16, data word width
- Tn, 16, lanes per group and entries per eDRAM line
- OFFSET_SZ, 4, index width per entry
- EADDR_SZ, 10, eDRAM line address width

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_start  in  1  pulse; loads i_base_addr, clears state; honoured only in IDLE
- i_base_addr  in  EADDR_SZ  first line address
- i_valid  in  1  input group valid
- o_ready  out  1  packer can accept a group this cycle
- i_data  in  Tn*N  compacted values; lane k at bits [k*N +: N]
- i_idx  in  Tn*OFFSET_SZ  index per lane
- i_count  in  OFFSET_SZ+1  number of valid lanes (lanes 0..i_count-1)
- i_flush  in  1  pulse; end of stream, honoured only in RUN
- o_wr_en  out  1  eDRAM write request
- i_wr_ready  in  1  eDRAM accepts the write
- o_wr_addr  out  EADDR_SZ  line address
- o_wr_data  out  Tn*N  line values
- o_wr_idx  out  Tn*OFFSET_SZ  line indices
- o_wr_count  out  OFFSET_SZ+1  valid entries in the line (Tn, or fewer for the final line)
- o_lines  out  EADDR_SZ  lines written since the last start
- o_done  out  1  one-cycle pulse after the flush completes

## Operation
- States: IDLE, RUN, FLUSH, DONE. Reset enters IDLE.
- IDLE -> RUN on i_start. This loads addr = i_base_addr and clears F (fill level) and o_lines.
- Staging buffer holds 2*Tn entries (value + index).
- F range: 0..2*Tn-1.
- o_ready = (state == RUN) && (F < Tn). It is a combinational function of registered state only.
- Accept (i_valid && o_ready):
  - Lanes 0..c-1 are appended at buffer positions F..F+c-1, where c = min(i_count, Tn).
  - F += c.
  - i_count = 0 is accepted with no change.
  - i_count > Tn is clamped to Tn.
- When F >= Tn, o_wr_en asserts with:
  - o_wr_data/o_wr_idx = buffer entries 0..Tn-1
  - o_wr_count = Tn
  - o_wr_addr = addr
- Write handshake (o_wr_en && i_wr_ready):
  - buffer shifts down by Tn; F -= Tn
  - addr += 1, modulo 2^EADDR_SZ (wraps silently)
  - o_lines += 1, modulo 2^EADDR_SZ
- Accept and write are mutually exclusive by construction (F < Tn vs F >= Tn).
- i_flush in RUN latches the flush request and moves to FLUSH next cycle.
  - If i_flush coincides with an accept, the accept completes first.
- FLUSH:
  - o_ready = 0.
  - Full lines drain first.
  - Then, if 0 < F < Tn, one partial line is written: o_wr_count = F, and lanes F..Tn-1 carry data = 0 and idx = 0.
  - When F == 0, go to DONE.
- DONE: o_done = 1 for exactly one cycle, then IDLE.
- i_start outside IDLE is ignored. i_flush outside RUN is ignored.

## Timing
- Reset (asynchronous assert, synchronous release):
  - all outputs 0: o_ready, o_wr_en, o_wr_addr, o_wr_data, o_wr_idx, o_wr_count, o_lines, o_done
  - buffer contents cleared
- o_wr_* are registered.
- o_wr_en rises the cycle after the accept that makes F >= Tn.
- o_wr_* stay stable while o_wr_en && !i_wr_ready.
- After a write handshake:
  - if F is still >= Tn, o_wr_en stays high with the next line on the following cycle;
  - otherwise o_ready is 1 on the following cycle.
- Minimum latency: first accept to first o_wr_en is 1 cycle, when a single group has i_count = Tn.
- Reset mid-write drops the pending line; no partial write is emitted.
- i_start and i_flush arriving on the same cycle in IDLE: i_start is taken, i_flush is ignored.

## Test plan
- Reset, start base=0x010, 4 groups of i_count=8, i_wr_ready=1 -> 2 writes, addr 0x010 and 0x011, o_wr_count=16, values in order, o_lines=2.
- Start base=0x3FF, 2 groups of i_count=16 -> writes at 0x3FF then 0x000 (wrap).
- Group of i_count=12, group of 12, flush -> line of 16 (entries 0..15), partial line o_wr_count=8 with lanes 8..15 zero, o_done pulses once, then IDLE.
- Hold i_wr_ready=0 for 5 cycles with a line pending -> o_wr_* stable, o_ready=0; release -> exactly one write.
- Edge inputs:
  - i_count=0 groups -> no writes.
  - i_count=20 -> clamped to 16, one line written.
  - flush with F=0 -> no write, o_done pulses.
- Assert rst mid-stream with F=10 -> all outputs 0 immediately; a new i_start restarts cleanly with o_lines=0.
